kuznechik_apb_master: RTL and testbench

APB master sequencer that sits directly upstream of the Kuznechik APB slave. It accepts one 128-bit plaintext block on a valid/ready stream and performs the full APB register sequence: load the four data-in words, kick the cipher, poll status, then read back the four data-out words. It presents the 128-bit result on an output valid/ready stream. Any slave error or poll timeout aborts the operation and is reported on `err_o`.

---
 rtl/kuznechik_apb_master.sv | 236 +++++++++++++++++++++++
 tb/tb_kuznechik_apb_master.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kuznechik_apb_master.sv
// ---------------------------------------------------------------------------
// kuznechik_apb_master
//
// Sequences one Kuznechik block through the APB cipher slave. The sequence is
// four data-in writes, a control write that sets request, status polling
// until valid, and four data-out reads. The result is then offered on an
// output valid/ready stream. A slave error, or a poll timeout, aborts the
// block and produces a one-cycle err_o pulse.
//
// Parameters:
//   BASE_ADDR   base byte address of the cipher slave
//   POLL_LIMIT  number of non-valid status reads that triggers a timeout
//
// Ports:
//   PCLK, PRESET             clock, asynchronous active-high reset
//   in_valid_i/in_ready_o    plaintext stream handshake
//   in_data_i[127:0]         plaintext block
//   out_valid_o/out_ready_i  ciphertext stream handshake
//   out_data_o[127:0]        ciphertext block
//   err_o                    one-cycle abort pulse
//   PADDR..PSLVERR           APB master interface
//
// State table:
//   state     | meaning
//   IDLE      | waiting for a plaintext block (in_ready_o=1)
//   WR_DATA   | writing data-in word idx
//   WR_CTRL   | writing resetn=1, request=1 to the control word
//   POLL      | reading status until valid, or until the timeout
//   RD_DATA   | reading data-out word idx
//   OUT       | presenting the result until out_ready_i
//
// Each bus state runs the sub-phases SETUP -> ACCESS (repeated while PREADY=0)
// -> GAP. The state that follows a transfer is chosen at completion, and the
// GAP phase provides the mandatory bus-idle cycle. In IDLE and OUT, a pending
// GAP phase holds off the stream handshakes for that one cycle.
// ---------------------------------------------------------------------------
module kuznechik_apb_master #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          POLL_LIMIT = 1024
) (
    input  logic         PCLK,
    input  logic         PRESET,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_data_o,
    output logic         err_o,
    output logic [31:0]  PADDR,
    output logic         PSEL,
    output logic         PENABLE,
    output logic         PWRITE,
    output logic [31:0]  PWDATA,
    output logic [3:0]   PSTRB,
    output logic [2:0]   PPROT,
    input  logic         PREADY,
    input  logic [31:0]  PRDATA,
    input  logic         PSLVERR
);

    localparam logic [15:0] POLL_MAX  = 16'(POLL_LIMIT);
    localparam logic [31:0] OFS_CTRL  = 32'h0000_0000;
    localparam logic [31:0] OFS_DIN   = 32'h0000_0004;
    localparam logic [31:0] OFS_DOUT  = 32'h0000_0014;
    localparam logic [31:0] CTRL_WORD = 32'h0000_0101;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_DATA = 3'd1,
        S_WR_CTRL = 3'd2,
        S_POLL    = 3'd3,
        S_RD_DATA = 3'd4,
        S_OUT     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        P_SETUP  = 2'd0,
        P_ACCESS = 2'd1,
        P_GAP    = 2'd2
    } phase_t;

    state_t         state, state_nxt;
    phase_t         phase, phase_nxt;
    logic [1:0]     idx, idx_nxt;
    logic [15:0]    poll_cnt, poll_cnt_nxt;
    logic [127:0]   in_buf, in_buf_nxt;
    logic [127:0]   out_buf, out_buf_nxt;
    logic           err_q, err_nxt;
    logic           bus_state;
    logic [15:0]    poll_inc;

    assign bus_state = (state == S_WR_DATA) || (state == S_WR_CTRL) ||
                       (state == S_POLL)    || (state == S_RD_DATA);
    assign poll_inc  = poll_cnt + 16'd1;

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= S_IDLE;
            phase    <= P_SETUP;
            idx      <= 2'd0;
            poll_cnt <= 16'd0;
            in_buf   <= '0;
            out_buf  <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            idx      <= idx_nxt;
            poll_cnt <= poll_cnt_nxt;
            in_buf   <= in_buf_nxt;
            out_buf  <= out_buf_nxt;
            err_q    <= err_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        idx_nxt      = idx;
        poll_cnt_nxt = poll_cnt;
        in_buf_nxt   = in_buf;
        out_buf_nxt  = out_buf;
        err_nxt      = 1'b0;

        case (state)
            S_IDLE: begin
                if (phase == P_GAP) begin
                    phase_nxt = P_SETUP;
                end else if (in_valid_i) begin
                    in_buf_nxt   = in_data_i;
                    poll_cnt_nxt = 16'd0;
                    idx_nxt      = 2'd0;
                    state_nxt    = S_WR_DATA;
                    phase_nxt    = P_SETUP;
                end
            end

            S_OUT: begin
                if (phase == P_GAP) begin
                    phase_nxt = P_SETUP;
                end else if (out_ready_i) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                case (phase)
                    P_SETUP: phase_nxt = P_ACCESS;
                    P_GAP:   phase_nxt = P_SETUP;
                    default: begin
                        if (PREADY) begin
                            phase_nxt = P_GAP;
                            if (PSLVERR) begin
                                state_nxt   = S_IDLE;
                                err_nxt     = 1'b1;
                                out_buf_nxt = '0;
                            end else begin
                                case (state)
                                    S_WR_DATA: begin
                                        idx_nxt = idx + 2'd1;
                                        if (idx == 2'd3) state_nxt = S_WR_CTRL;
                                    end
                                    S_WR_CTRL: state_nxt = S_POLL;
                                    S_POLL: begin
                                        if (PRDATA[16]) begin
                                            state_nxt = S_RD_DATA;
                                            idx_nxt   = 2'd0;
                                        end else begin
                                            poll_cnt_nxt = poll_inc;
                                            if (poll_inc == POLL_MAX) begin
                                                state_nxt   = S_IDLE;
                                                err_nxt     = 1'b1;
                                                out_buf_nxt = '0;
                                            end
                                        end
                                    end
                                    S_RD_DATA: begin
                                        out_buf_nxt[{idx, 5'b00000} +: 32] = PRDATA;
                                        idx_nxt = idx + 2'd1;
                                        if (idx == 2'd3) state_nxt = S_OUT;
                                    end
                                    default: state_nxt = S_IDLE;
                                endcase
                            end
                        end
                    end
                endcase
            end
        endcase
    end

    // Output logic. Address and data are decoded from the registered state, so
    // they stay stable across SETUP and every ACCESS cycle.
    always_comb begin
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
        PWRITE      = 1'b0;
        PADDR       = 32'h0;
        PWDATA      = 32'h0;
        PSTRB       = 4'h0;
        PPROT       = 3'b000;
        in_ready_o  = (state == S_IDLE) && (phase != P_GAP);
        out_valid_o = (state == S_OUT)  && (phase != P_GAP);
        out_data_o  = out_buf;
        err_o       = err_q;

        if (bus_state && (phase != P_GAP)) begin
            PSEL    = 1'b1;
            PENABLE = (phase == P_ACCESS);
            case (state)
                S_WR_DATA: begin
                    PWRITE = 1'b1;
                    PADDR  = BASE_ADDR + OFS_DIN + {28'h0, idx, 2'b00};
                    PWDATA = in_buf[{idx, 5'b00000} +: 32];
                    PSTRB  = 4'hF;
                end
                S_WR_CTRL: begin
                    PWRITE = 1'b1;
                    PADDR  = BASE_ADDR + OFS_CTRL;
                    PWDATA = CTRL_WORD;
                    PSTRB  = 4'b0011;
                end
                S_POLL: begin
                    PADDR = BASE_ADDR + OFS_CTRL;
                end
                default: begin
                    PADDR = BASE_ADDR + OFS_DOUT + {28'h0, idx, 2'b00};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kuznechik_apb_master.sv
module tb_kuznechik_apb_master;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         err;
    logic [31:0]  paddr;
    logic         psel, penable, pwrite;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [2:0]   pprot;
    logic         pready;
    logic [31:0]  prdata;
    logic         pslverr;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    localparam logic [127:0] EXP_OUT = 128'h44444444_33333333_22222222_11111111;

    always #5 clk = ~clk;

    kuznechik_apb_master #(.BASE_ADDR(32'h0), .POLL_LIMIT(4)) dut (
        .PCLK(clk), .PRESET(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .err_o(err),
        .PADDR(paddr), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PREADY(pready), .PRDATA(prdata), .PSLVERR(pslverr)
    );

    // ---------------- slave model ----------------
    int          wait_states = 0;
    int          valid_poll  = 2;      // 0: status never reports valid
    bit          err_en      = 1'b0;
    logic [31:0] err_addr    = 32'h0;

    int          wait_cnt;
    int          polls_seen;
    int          log_n = 0;
    int          stab_err = 0;
    int          err_pulses = 0;
    int          ov_rises = 0;
    logic        ov_prev = 1'b0;
    logic [31:0] log_addr [0:63];
    logic [31:0] log_data [0:63];
    logic        log_wr   [0:63];
    logic [3:0]  log_strb [0:63];
    logic [31:0] s_addr, s_data;
    logic        s_wr;
    logic [3:0]  s_strb;
    logic        vld;
    logic [31:0] prdata_m;

    assign vld     = (valid_poll != 0) && (polls_seen + 1 >= valid_poll);
    assign pready  = (wait_cnt >= wait_states);
    assign pslverr = err_en && psel && penable && (paddr == err_addr);
    assign prdata  = prdata_m;

    always_comb begin
        prdata_m = 32'hDEAD_BEEF;
        if (paddr == 32'h0)
            prdata_m = {15'h0, vld, 16'h0101};
        else if (paddr >= 32'h14 && paddr <= 32'h20)
            prdata_m = 32'h1111_1111 * ((paddr - 32'h10) >> 2);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt   <= 0;
            polls_seen <= 0;
        end else begin
            if (psel && !penable) begin
                wait_cnt <= 0;
                s_addr   <= paddr;
                s_data   <= pwdata;
                s_wr     <= pwrite;
                s_strb   <= pstrb;
            end else if (psel && penable) begin
                if (paddr !== s_addr || pwdata !== s_data || pwrite !== s_wr || pstrb !== s_strb)
                    stab_err <= stab_err + 1;
                if (!pready) begin
                    wait_cnt <= wait_cnt + 1;
                end else begin
                    if (log_n < 64) begin
                        log_addr[log_n] <= paddr;
                        log_data[log_n] <= pwdata;
                        log_wr[log_n]   <= pwrite;
                        log_strb[log_n] <= pstrb;
                    end
                    log_n <= log_n + 1;
                    if (paddr == 32'h0 && pwrite)  polls_seen <= 0;
                    if (paddr == 32'h0 && !pwrite) polls_seen <= polls_seen + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (err) err_pulses <= err_pulses + 1;
        if (out_valid && !ov_prev) ov_rises <= ov_rises + 1;
        ov_prev <= out_valid;
    end

    // ---------------- helpers (all aligned to posedge+1) ----------------
    task automatic start_block(input logic [127:0] din, output bit ok);
        int guard = 0;
        in_data  = din;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        ok = (guard < 200);
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!out_valid && !err && n < 400) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if ({psel, penable, pwrite, paddr, pwdata, pstrb, pprot, out_valid, out_data, err} !== '0)
            $display("FAIL reset_outputs: psel=%b pen=%b pwr=%b paddr=%h pwdata=%h pstrb=%h pprot=%h ov=%b od=%h err=%b, required all zero",
                     psel, penable, pwrite, paddr, pwdata, pstrb, pprot, out_valid, out_data, err);
        else pass_cnt++;
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
        else pass_cnt++;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait();
        logic [127:0] din = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        bit ok;
        int n, base;
        bit seq_ok;
        wait_states = 0; valid_poll = 2; err_en = 1'b0;
        base = log_n;
        start_block(din, ok);
        chk_cnt++;
        if (!(ok && psel && !penable && pwrite && paddr == 32'h4 && pwdata == din[31:0] && pstrb == 4'hF))
            $display("FAIL zw_first_setup: ok=%b psel=%b pen=%b pwr=%b paddr=%h pwdata=%h pstrb=%h, required setup write 0x4 %h F",
                     ok, psel, penable, pwrite, paddr, pwdata, pstrb, din[31:0]);
        else pass_cnt++;
        wait_done(n);
        chk_cnt++;
        if (n !== 34 || out_valid !== 1'b1) $display("FAIL zw_latency: cycle %0d ov=%b, required cycle 34 ov=1", n, out_valid);
        else pass_cnt++;
        chk_cnt++;
        if (out_data !== EXP_OUT) $display("FAIL zw_data: got %h required %h", out_data, EXP_OUT);
        else pass_cnt++;
        seq_ok = (log_n - base == 11);
        for (int k = 0; k < 4; k++)
            if (!(log_wr[base+k] && log_addr[base+k] == 32'h4 + 4*k && log_data[base+k] == din[32*k +: 32] && log_strb[base+k] == 4'hF))
                seq_ok = 1'b0;
        chk_cnt++;
        if (!seq_ok) $display("FAIL zw_data_writes: %0d transfers logged, required 11 with data-in writes in order", log_n - base);
        else pass_cnt++;
        chk_cnt++;
        if (!(log_wr[base+4] && log_addr[base+4] == 32'h0 && log_data[base+4] == 32'h0000_0101 && log_strb[base+4] == 4'b0011))
            $display("FAIL zw_ctrl_write: wr=%b addr=%h data=%h strb=%h required 1 0 00000101 3",
                     log_wr[base+4], log_addr[base+4], log_data[base+4], log_strb[base+4]);
        else pass_cnt++;
        seq_ok = 1'b1;
        for (int k = 5; k < 11; k++) begin
            if (log_wr[base+k] || log_data[base+k] != 0 || log_strb[base+k] != 0) seq_ok = 1'b0;
            if (log_addr[base+k] != ((k < 7) ? 32'h0 : 32'h14 + 4*(k-7))) seq_ok = 1'b0;
        end
        chk_cnt++;
        if (!seq_ok) $display("FAIL zw_reads: read sequence wrong, required 2 polls of 0x0 then 0x14..0x20 with PWDATA=0 PSTRB=0");
        else pass_cnt++;
        chk_cnt++;
        if (pprot !== 3'b000) $display("FAIL zw_pprot: got %b required 000", pprot);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_wait_states();
        bit ok;
        int n, s0;
        wait_states = 3; valid_poll = 2; err_en = 1'b0;
        s0 = stab_err;
        start_block(128'h1, ok);
        wait_done(n);
        chk_cnt++;
        if (!ok || n !== 67 || out_data !== EXP_OUT)
            $display("FAIL ws_result: cycle %0d data %h, required cycle 67 data %h", n, out_data, EXP_OUT);
        else pass_cnt++;
        chk_cnt++;
        if (stab_err !== s0) $display("FAIL ws_stability: %0d unstable access cycles, required 0", stab_err - s0);
        else pass_cnt++;
        consume();
        wait_states = 0;
    endtask

    task automatic test_timeout();
        bit ok;
        int n, base, e0, o0, reads;
        valid_poll = 0; err_en = 1'b0;
        base = log_n; e0 = err_pulses; o0 = ov_rises;
        start_block(128'h2, ok);
        wait_done(n);
        chk_cnt++;
        if (!ok || n !== 27 || err !== 1'b1) $display("FAIL to_err_timing: cycle %0d err=%b, required cycle 27 err=1", n, err);
        else pass_cnt++;
        reads = 0;
        for (int k = base; k < log_n; k++)
            if (!log_wr[k] && log_addr[k] == 32'h0) reads++;
        chk_cnt++;
        if (reads !== 4 || log_n - base !== 9) $display("FAIL to_poll_count: %0d polls %0d transfers, required 4 and 9", reads, log_n - base);
        else pass_cnt++;
        repeat (3) begin @(posedge clk); #1; end
        chk_cnt++;
        if (in_ready !== 1'b1 || err_pulses - e0 !== 1 || ov_rises !== o0 || psel !== 1'b0)
            $display("FAIL to_after: in_ready=%b err pulses=%0d ov rises=%0d psel=%b, required 1 1 0 0",
                     in_ready, err_pulses - e0, ov_rises - o0, psel);
        else pass_cnt++;
        valid_poll = 2;
    endtask

    task automatic test_slverr();
        bit ok;
        int n, base, e0;
        err_en = 1'b1; err_addr = 32'hC; valid_poll = 2;
        base = log_n; e0 = err_pulses;
        start_block(128'h3, ok);
        wait_done(n);
        chk_cnt++;
        if (!ok || n !== 9 || err !== 1'b1) $display("FAIL se_err_timing: cycle %0d err=%b, required cycle 9 err=1", n, err);
        else pass_cnt++;
        repeat (4) begin @(posedge clk); #1; end
        chk_cnt++;
        if (log_n - base !== 3 || log_addr[base+2] !== 32'hC || err_pulses - e0 !== 1 || in_ready !== 1'b1)
            $display("FAIL se_abort: %0d transfers last addr %h err pulses %0d in_ready %b, required 3 0000000c 1 1",
                     log_n - base, log_addr[base+2], err_pulses - e0, in_ready);
        else pass_cnt++;
        err_en = 1'b0;
        start_block(128'h4, ok);
        wait_done(n);
        chk_cnt++;
        if (n !== 34 || out_data !== EXP_OUT) $display("FAIL se_recover: cycle %0d data %h, required 34 %h", n, out_data, EXP_OUT);
        else pass_cnt++;
        consume();
    endtask

    task automatic test_back_pressure();
        bit ok, stable;
        int n;
        start_block(128'h5, ok);
        wait_done(n);
        stable = ok && out_valid;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_data !== EXP_OUT || in_ready !== 1'b0 || psel !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
        end
        chk_cnt++;
        if (!stable || out_valid !== 1'b1) $display("FAIL bp_hold: ov=%b data=%h in_ready=%b, required output held with in_ready=0",
                                                    out_valid, out_data, in_ready);
        else pass_cnt++;
        consume();
        chk_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp_release: in_ready=%b ov=%b required 1 0", in_ready, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok, found;
        int n;
        found = 1'b0;
        start_block(128'h6, ok);
        for (int i = 0; i < 100 && !found; i++) begin
            if (psel && penable && !pwrite && paddr == 32'h14) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        #2 rst = 1'b1;
        #1;
        chk_cnt++;
        if (!found || psel !== 1'b0 || penable !== 1'b0 || err !== 1'b0)
            $display("FAIL rm_async: found=%b psel=%b pen=%b err=%b, required 1 0 0 0", found, psel, penable, err);
        else pass_cnt++;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        start_block(128'h7, ok);
        wait_done(n);
        chk_cnt++;
        if (!ok || n !== 34 || out_data !== EXP_OUT) $display("FAIL rm_fresh: cycle %0d data %h, required 34 %h", n, out_data, EXP_OUT);
        else pass_cnt++;
        consume();
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_timeout();
        test_slverr();
        test_back_pressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
